// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating counters.
// Detects mispredicts at the ALU stage and issues a registered one-cycle redirect.
module branch_predictor #(
    parameter int unsigned ENTRIES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] fetch_pc,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    input  logic        upd_pred_taken,
    input  logic [31:0] upd_pred_target,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic [15:0] branch_count,
    output logic [15:0] mispredict_count
);

    localparam int unsigned IDX  = $clog2(ENTRIES);
    localparam int unsigned TAGW = 32 - IDX - 2;

    logic            validQ  [ENTRIES];
    logic [TAGW-1:0] tagQ    [ENTRIES];
    logic [31:0]     targetQ [ENTRIES];
    logic [1:0]      ctrQ    [ENTRIES];

    logic [IDX-1:0]  fetchIdx;
    logic [TAGW-1:0] fetchTag;
    logic [IDX-1:0]  updIdx;
    logic [TAGW-1:0] updTag;
    logic            fetchHit;
    logic            updHit;
    logic [1:0]      ctrNext;
    logic            mispredict;
    logic [31:0]     correctPc;

    assign fetchIdx = fetch_pc[IDX+1:2];
    assign fetchTag = fetch_pc[31:IDX+2];
    assign updIdx   = upd_pc[IDX+1:2];
    assign updTag   = upd_pc[31:IDX+2];

    // Fetch-side lookup reads the registered table, so same-cycle updates are not visible yet
    always_comb begin
        fetchHit    = validQ[fetchIdx] && (tagQ[fetchIdx] == fetchTag);
        pred_taken  = fetchHit && ctrQ[fetchIdx][1];
        pred_target = fetch_pc + 32'd4;
        if (pred_taken) begin
            pred_target = targetQ[fetchIdx];
        end
    end

    // Update-side hit detection, saturating counter step and mispredict check
    always_comb begin
        updHit  = validQ[updIdx] && (tagQ[updIdx] == updTag);
        ctrNext = ctrQ[updIdx];
        if (upd_taken) begin
            if (ctrQ[updIdx] != 2'b11) begin
                ctrNext = ctrQ[updIdx] + 2'd1;
            end
        end else begin
            if (ctrQ[updIdx] != 2'b00) begin
                ctrNext = ctrQ[updIdx] - 2'd1;
            end
        end
        mispredict = upd_valid &&
                     ((upd_taken != upd_pred_taken) ||
                      (upd_taken && (upd_target != upd_pred_target)));
        correctPc  = upd_taken ? upd_target : (upd_pc + 32'd4);
    end

    // Table state: train on hits, allocate only on taken misses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                validQ[i]  <= 1'b0;
                tagQ[i]    <= '0;
                targetQ[i] <= '0;
                ctrQ[i]    <= 2'b01;
            end
        end else if (upd_valid) begin
            if (updHit) begin
                ctrQ[updIdx] <= ctrNext;
                if (upd_taken) begin
                    targetQ[updIdx] <= upd_target;
                end
            end else if (upd_taken) begin
                validQ[updIdx]  <= 1'b1;
                tagQ[updIdx]    <= updTag;
                targetQ[updIdx] <= upd_target;
                ctrQ[updIdx]    <= 2'b10;
            end
        end
    end

    // Redirect pulse and statistics
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            redirect_valid   <= 1'b0;
            redirect_pc      <= '0;
            branch_count     <= '0;
            mispredict_count <= '0;
        end else begin
            redirect_valid <= mispredict;
            if (mispredict) begin
                redirect_pc      <= correctPc;
                mispredict_count <= mispredict_count + 16'd1;
            end
            if (upd_valid) begin
                branch_count <= branch_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: stimulus queues expected redirects,
// a negedge monitor matches each redirect pulse against the queue.
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] fetch_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_pred_taken;
    logic [31:0] upd_pred_target;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [15:0] branch_count;
    logic [15:0] mispredict_count;

    typedef struct {
        int unsigned cyc;
        logic [31:0] pc;
    } exp_t;

    exp_t        expQ[$];
    int unsigned cycleCnt = 0;
    int          checks   = 0;
    int          failures = 0;

    branch_predictor #(.ENTRIES(16)) dut (
        .clk(clk),
        .rst(rst),
        .fetch_pc(fetch_pc),
        .pred_taken(pred_taken),
        .pred_target(pred_target),
        .upd_valid(upd_valid),
        .upd_pc(upd_pc),
        .upd_taken(upd_taken),
        .upd_target(upd_target),
        .upd_pred_taken(upd_pred_taken),
        .upd_pred_target(upd_pred_target),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .branch_count(branch_count),
        .mispredict_count(mispredict_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    // Monitor: every redirect pulse must match the oldest expected entry, in the right cycle
    always @(negedge clk) begin
        exp_t e;
        if (redirect_valid) begin
            checks++;
            if (expQ.size() == 0) begin
                failures++;
                $display("FAIL unexpectedRedirect actual pc=%h cycle=%0d required=no pulse",
                         redirect_pc, cycleCnt);
            end else begin
                e = expQ.pop_front();
                if (e.cyc != cycleCnt || e.pc != redirect_pc) begin
                    failures++;
                    $display("FAIL redirect actual pc=%h cycle=%0d required pc=%h cycle=%0d",
                             redirect_pc, cycleCnt, e.pc, e.cyc);
                end
            end
        end else if (expQ.size() > 0 && expQ[0].cyc <= cycleCnt) begin
            checks++;
            failures++;
            e = expQ.pop_front();
            $display("FAIL missingRedirect actual=no pulse cycle=%0d required pc=%h cycle=%0d",
                     cycleCnt, e.pc, e.cyc);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic checkFetch(input logic [31:0] pc, input logic expTaken,
                              input logic [31:0] expTarget);
        fetch_pc = pc;
        #1;
        check("predTaken", 32'(pred_taken), 32'(expTaken));
        check("predTarget", pred_target, expTarget);
    endtask

    task automatic checkCounts(input logic [15:0] expBranch, input logic [15:0] expMis);
        check("branchCount", 32'(branch_count), 32'(expBranch));
        check("mispredictCount", 32'(mispredict_count), 32'(expMis));
    endtask

    // Present an update for the coming edge; queue the redirect it should cause
    task automatic upd(input logic [31:0] pc, input logic taken, input logic [31:0] target,
                       input logic pTaken, input logic [31:0] pTarget,
                       input logic expMis, input logic [31:0] expPc);
        exp_t e;
        upd_valid       = 1'b1;
        upd_pc          = pc;
        upd_taken       = taken;
        upd_target      = target;
        upd_pred_taken  = pTaken;
        upd_pred_target = pTarget;
        if (expMis) begin
            e.cyc = cycleCnt + 1;
            e.pc  = expPc;
            expQ.push_back(e);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        upd_valid = 1'b0;
    endtask

    initial begin
        rst             = 1'b1;
        fetch_pc        = '0;
        upd_valid       = 1'b0;
        upd_pc          = '0;
        upd_taken       = 1'b0;
        upd_target      = '0;
        upd_pred_taken  = 1'b0;
        upd_pred_target = '0;
        repeat (3) @(negedge clk);
        check("rstRedirectValid", 32'(redirect_valid), 32'd0);
        check("rstRedirectPc", redirect_pc, 32'd0);
        checkCounts(16'd0, 16'd0);
        @(negedge clk);
        rst = 1'b0;

        // Cold lookups, including the +4 wrap
        checkFetch(32'h100, 1'b0, 32'h104);
        checkFetch(32'hFFFF_FFFC, 1'b0, 32'h0);

        // Allocation on a taken miss
        upd(32'h100, 1'b1, 32'h80, 1'b0, 32'h104, 1'b1, 32'h80);
        tick();
        checkFetch(32'h100, 1'b1, 32'h80);
        checkCounts(16'd1, 16'd1);

        // Hysteresis: 10 -> 01 -> 10 -> 11 -> 10, back-to-back redirects
        upd(32'h100, 1'b0, 32'h0, 1'b1, 32'h80, 1'b1, 32'h104);
        tick();
        checkFetch(32'h100, 1'b0, 32'h104);
        upd(32'h100, 1'b1, 32'h80, 1'b0, 32'h104, 1'b1, 32'h80);
        tick();
        checkFetch(32'h100, 1'b1, 32'h80);
        upd(32'h100, 1'b1, 32'h80, 1'b1, 32'h80, 1'b0, 32'h0);
        tick();
        upd(32'h100, 1'b0, 32'h0, 1'b1, 32'h80, 1'b1, 32'h104);
        tick();
        checkFetch(32'h100, 1'b1, 32'h80);

        // Right direction, wrong target
        upd(32'h100, 1'b1, 32'h90, 1'b1, 32'h80, 1'b1, 32'h90);
        tick();
        checkFetch(32'h100, 1'b1, 32'h90);
        checkCounts(16'd6, 16'd5);

        // Aliasing: 0x140 shares index 0 and replaces 0x100
        upd(32'h140, 1'b1, 32'h400, 1'b0, 32'h144, 1'b1, 32'h400);
        tick();
        checkFetch(32'h100, 1'b0, 32'h104);
        checkFetch(32'h140, 1'b1, 32'h400);
        checkCounts(16'd7, 16'd6);

        // Not-taken miss leaves the table alone
        upd(32'h180, 1'b0, 32'h0, 1'b0, 32'h184, 1'b0, 32'h0);
        tick();
        checkFetch(32'h140, 1'b1, 32'h400);
        checkFetch(32'h180, 1'b0, 32'h184);
        checkCounts(16'd8, 16'd6);

        // Same-cycle lookup and allocation
        upd(32'h200, 1'b1, 32'h500, 1'b0, 32'h204, 1'b1, 32'h500);
        checkFetch(32'h200, 1'b0, 32'h204);
        tick();
        checkFetch(32'h200, 1'b1, 32'h500);
        checkCounts(16'd9, 16'd7);

        // Reset right after a mispredicting update cancels its redirect
        upd(32'h240, 1'b1, 32'h600, 1'b0, 32'h244, 1'b0, 32'h0);
        @(posedge clk);
        #1;
        rst       = 1'b1;
        upd_valid = 1'b0;
        @(negedge clk);
        check("midRstRedirectValid", 32'(redirect_valid), 32'd0);
        checkCounts(16'd0, 16'd0);
        checkFetch(32'h200, 1'b0, 32'h204);
        checkFetch(32'h240, 1'b0, 32'h244);

        // Updates presented during reset are ignored
        upd(32'h300, 1'b1, 32'h700, 1'b0, 32'h304, 1'b0, 32'h0);
        tick();
        rst = 1'b0;
        checkFetch(32'h300, 1'b0, 32'h304);
        checkCounts(16'd0, 16'd0);

        // Branch counter wrap with correctly predicted not-taken branches
        upd(32'h1000, 1'b0, 32'h0, 1'b0, 32'h1004, 1'b0, 32'h0);
        repeat (65535) @(negedge clk);
        checkCounts(16'hFFFF, 16'd0);
        tick();
        checkCounts(16'd0, 16'd0);

        repeat (3) @(negedge clk);
        checks++;
        if (expQ.size() != 0) begin
            failures++;
            $display("FAIL pendingRedirects actual=%0d required=0", expQ.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have parameter ENTRIES, default 16, meaning the number of predictor entries; legal values are powers of two from 4 to 64.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port fetch_pc, input, 32 bits: PC of the instruction being fetched.
REQ-005 SHALL have port pred_taken, output, 1 bit: prediction that fetch_pc is a taken branch.
REQ-006 SHALL have port pred_target, output, 32 bits: predicted target, valid when pred_taken=1.
REQ-007 SHALL have port upd_valid, input, 1 bit: a conditional branch is resolved in the ALU stage this cycle.
REQ-008 SHALL have port upd_pc, input, 32 bits: PC of the resolved branch.
REQ-009 SHALL have port upd_taken, input, 1 bit: resolved outcome from the ALU-stage branch comparator.
REQ-010 SHALL have port upd_target, input, 32 bits: computed branch target.
REQ-011 SHALL have port upd_pred_taken, input, 1 bit: the prediction that was carried down the pipeline with this branch.
REQ-012 SHALL have port upd_pred_target, input, 32 bits: the target that was carried down the pipeline with this branch.
REQ-013 SHALL have port redirect_valid, output, 1 bit: one-cycle pulse requesting a fetch redirect and flush.
REQ-014 SHALL have port redirect_pc, output, 32 bits: the correct fetch PC when redirect_valid=1.
REQ-015 SHALL have ports branch_count and mispredict_count, outputs, 16 bits each: statistics counters.

Function
REQ-016 SHALL index the tables with pc[IDX+1:2], where IDX=log2(ENTRIES), and SHALL tag them with pc[31:IDX+2].
REQ-017 SHALL hold, per entry: a valid bit, a tag, a 32-bit target and a 2-bit counter.
- Counter encoding: 00=strong not-taken, 01=weak not-taken, 10=weak taken, 11=strong taken.
REQ-018 SHALL drive pred_taken combinationally, in the same cycle as fetch_pc, as valid AND tag match AND counter[1].
REQ-019 SHALL drive pred_target from the indexed entry's target when pred_taken=1, and SHALL drive it to fetch_pc+4 otherwise.
REQ-020 SHALL, on an update hit (upd_valid, entry valid, tag match), change the counter at the clock edge as follows.
- upd_taken=1: counter increments, saturating at 11; target is overwritten with upd_target.
- upd_taken=0: counter decrements, saturating at 00; target is unchanged.
REQ-021 SHALL, on an update miss with upd_taken=1, allocate or replace the entry: valid=1, tag from upd_pc, target=upd_target, counter=10.
REQ-022 SHALL NOT modify any entry on an update miss with upd_taken=0.
REQ-023 SHALL return pre-update contents to a lookup that targets the same entry as an update in the same cycle; the new contents become visible the following cycle.
REQ-024 SHALL detect a mispredict when upd_valid=1 and either of the following holds.
- upd_taken differs from upd_pred_taken.
- upd_taken=1 and upd_target differs from upd_pred_target.
REQ-025 SHALL register a detected mispredict so that redirect_valid=1 exactly one cycle after the update cycle, lasting one cycle.
- redirect_pc = upd_target if upd_taken=1, else upd_pc+4, using the values captured from the update cycle.
REQ-026 SHALL hold redirect_valid=0 in any cycle not preceded by a mispredicting update.
- Back-to-back mispredicts produce back-to-back pulses, each with its own redirect_pc.
REQ-027 SHALL increment branch_count on every upd_valid and mispredict_count on every detected mispredict; both counters wrap from FFFF to 0000.
REQ-028 SHALL perform the upd_pc+4 and fetch_pc+4 additions modulo 2^32.

Reset
REQ-029 SHALL, while rst=1, asynchronously set every valid bit to 0 and every counter to 01.
REQ-030 SHALL, while rst=1, set redirect_valid=0, redirect_pc=0, branch_count=0 and mispredict_count=0.
REQ-031 SHALL, while rst=1, ignore any update presented; a pending redirect is cancelled.
REQ-032 SHALL, after reset, produce pred_taken=0 and pred_target=fetch_pc+4 for every fetch_pc.

Verification
REQ-033 Cold lookup: after reset, fetch_pc=0x100 -> pred_taken=0, pred_target=0x104.
REQ-034 Allocation: update pc=0x100, taken=1, target=0x80, pred_taken=0 -> redirect pulse next cycle with redirect_pc=0x80.
- Then fetch_pc=0x100 -> pred_taken=1, pred_target=0x80.
- Counts: mispredict_count=1, branch_count=1.
REQ-035 Hysteresis: from counter 10, one not-taken update -> 01, pred_taken=0; from counter 11, one not-taken update -> 10, pred_taken still 1.
- Not-taken mispredict yields redirect_pc=upd_pc+4.
REQ-036 Aliasing: entry holds pc=0x100; a taken update at pc=0x140 (ENTRIES=16) replaces it.
- fetch_pc=0x100 -> pred_taken=0.
- fetch_pc=0x140 -> pred_taken=1.
REQ-037 Same-cycle conflict: lookup and allocating update of 0x200 in one cycle -> lookup sees pred_taken=0; the next cycle sees 1.
REQ-038 Reset mid-operation: assert rst in the cycle after a mispredicting update -> no redirect pulse, all counters 0, all predictions not-taken.
- 65536 updates -> branch_count wraps to 0.
